// File: rtl/bp_me_cache_dma_concentrator_pkg.sv
// Shared types for the cache DMA concentrator.
//   BP_CACHE_DMA_PKT_S_DECLARE(addr_width) : macro declaring the {write_not_read, addr} packet struct
//   dma_conc_state_e                       : packet FSM states
//   safe_clog2                             : clog2 that never returns 0
`ifndef BP_CACHE_DMA_PKT_S_DEFINED
`define BP_CACHE_DMA_PKT_S_DEFINED
`define BP_CACHE_DMA_PKT_S_DECLARE(addr_width_mp) \
  typedef struct packed { \
    logic                     write_not_read; \
    logic [addr_width_mp-1:0] addr; \
  } bp_cache_dma_pkt_s
`endif

package bp_me_cache_dma_concentrator_pkg;

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_pkt_hold = 2'd1,
    e_wr_data  = 2'd2
  } dma_conc_state_e;

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_me_dma_tag_tracker.sv
// In-order tracker of channel ids for outstanding read packets, plus fill beat counter.
//   push_i/push_id_i : record the issuing channel of a read packet
//   fill_yumi_i      : one fill beat handed to the head channel
//   head_o           : channel owning the oldest outstanding read
//   empty_o          : no read outstanding
//   full_c_o         : no room for a push this cycle (accounts for a same-cycle pop)
//   pop_last_c_o     : this fill beat completes the head burst
module bp_me_dma_tag_tracker
  import bp_me_cache_dma_concentrator_pkg::*;
#(
  parameter int unsigned num_dma_p     = 4,
  parameter int unsigned burst_len_p   = 8,
  parameter int unsigned outstanding_p = 4,
  localparam int unsigned id_w_lp      = safe_clog2(num_dma_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [id_w_lp-1:0] push_id_i,
  input  logic               fill_yumi_i,
  output logic [id_w_lp-1:0] head_o,
  output logic               empty_o,
  output logic               full_c_o,
  output logic               pop_last_c_o
);

  localparam int unsigned ptr_w_lp  = safe_clog2(outstanding_p);
  localparam int unsigned cnt_w_lp  = $clog2(outstanding_p + 1);
  localparam int unsigned beat_w_lp = safe_clog2(burst_len_p + 1);

  logic [id_w_lp-1:0]   id_mem_q [outstanding_p];
  logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]  count_q, count_d;
  logic [beat_w_lp-1:0] beat_q, beat_d;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign head_o       = id_mem_q[rd_ptr_q];
  assign empty_o      = (count_q == '0);
  assign pop_last_c_o = fill_yumi_i & (beat_q == beat_w_lp'(burst_len_p - 1));
  // A pop in the same cycle frees an entry for a push.
  assign full_c_o     = ((count_q - cnt_w_lp'(pop_last_c_o)) == cnt_w_lp'(outstanding_p));

  // Pointer, occupancy and beat next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_last_c_o);
    beat_d   = beat_q;
    if (push_i)       wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_last_c_o) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (pop_last_c_o)     beat_d = '0;
    else if (fill_yumi_i) beat_d = beat_q + beat_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
    end
  end

  // Id storage needs no reset; occupancy qualifies every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i) id_mem_q[wr_ptr_q] <= push_id_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(push_i && full_c_o)) else $error("tag tracker overflow");
  end

endmodule

// File: rtl/bp_me_cache_dma_concentrator.sv
// Merges num_dma_p cache DMA channels onto one memory DMA port.
//   dma_pkt_*      : per-channel packets, round-robin arbitrated, 0-cycle pass-through
//   dma_data_*_i   : per-channel write data, forwarded as an atomic burst after a write packet
//   dma_data_*_o   : per-channel read fills, steered by the in-order tag tracker
//   mem_dma_*      : merged memory-side packet, write data and fill ports
module bp_me_cache_dma_concentrator
  import bp_me_cache_dma_concentrator_pkg::*;
#(
  parameter int unsigned num_dma_p     = 4,
  parameter int unsigned daddr_width_p = 32,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned burst_len_p   = 8,
  parameter int unsigned outstanding_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_dma_p*(1+daddr_width_p)-1:0] dma_pkt_i,
  input  logic [num_dma_p-1:0]                  dma_pkt_v_i,
  output logic [num_dma_p-1:0]                  dma_pkt_yumi_o,
  input  logic [num_dma_p*data_width_p-1:0]     dma_data_i,
  input  logic [num_dma_p-1:0]                  dma_data_v_i,
  output logic [num_dma_p-1:0]                  dma_data_yumi_o,
  output logic [num_dma_p*data_width_p-1:0]     dma_data_o,
  output logic [num_dma_p-1:0]                  dma_data_v_o,
  input  logic [num_dma_p-1:0]                  dma_data_ready_and_i,
  output logic [daddr_width_p:0]                mem_dma_pkt_o,
  output logic                                  mem_dma_pkt_v_o,
  input  logic                                  mem_dma_pkt_ready_and_i,
  output logic [data_width_p-1:0]               mem_dma_data_o,
  output logic                                  mem_dma_data_v_o,
  input  logic                                  mem_dma_data_ready_and_i,
  input  logic [data_width_p-1:0]               mem_dma_data_i,
  input  logic                                  mem_dma_data_v_i,
  output logic                                  mem_dma_data_ready_and_o
);

  localparam int unsigned pkt_w_lp = 1 + daddr_width_p;
  localparam int unsigned id_w_lp  = safe_clog2(num_dma_p);
  localparam int unsigned cnt_w_lp = safe_clog2(burst_len_p + 1);

  `BP_CACHE_DMA_PKT_S_DECLARE(daddr_width_p);

  bp_cache_dma_pkt_s       pkt_li  [num_dma_p];
  logic [data_width_p-1:0] wdata_li[num_dma_p];

  dma_conc_state_e     state_q, state_d;
  logic [id_w_lp-1:0]  rr_ptr_q, rr_ptr_d, lock_q, lock_d;
  logic [cnt_w_lp-1:0] wr_cnt_q, wr_cnt_d;

  logic [num_dma_p-1:0] eligible;
  logic                 grant_found, sel_v, push, fill_v, fill_yumi;
  logic [id_w_lp-1:0]   grant_id, sel_id, next_ptr, head_id;
  logic [31:0]          scan_idx;
  logic                 trk_empty, trk_full, trk_pop;

  // Unpack flat channel buses.
  always_comb begin
    for (int i = 0; i < num_dma_p; i++) begin
      pkt_li[i]   = dma_pkt_i[i*pkt_w_lp +: pkt_w_lp];
      wdata_li[i] = dma_data_i[i*data_width_p +: data_width_p];
    end
  end

  // Reads are only eligible while the tracker can take another id.
  always_comb begin
    for (int i = 0; i < num_dma_p; i++) begin
      eligible[i] = dma_pkt_v_i[i] & (pkt_li[i].write_not_read | ~trk_full);
    end
  end

  // Round robin: first eligible channel at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < num_dma_p; k++) begin
      scan_idx = (32'(rr_ptr_q) + 32'(k)) % 32'(num_dma_p);
      if (!grant_found && eligible[id_w_lp'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_id    = id_w_lp'(scan_idx);
      end
    end
  end

  // A stalled grant stays frozen on the latched channel until accepted.
  assign sel_id   = (state_q == e_pkt_hold) ? lock_q : grant_id;
  assign sel_v    = (state_q == e_pkt_hold) ? dma_pkt_v_i[lock_q] : grant_found;
  assign next_ptr = (sel_id == id_w_lp'(num_dma_p - 1)) ? '0 : sel_id + id_w_lp'(1);

  // Packet FSM next-state and memory-side packet / write-data outputs.
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    lock_d           = lock_q;
    wr_cnt_d         = wr_cnt_q;
    push             = 1'b0;
    dma_pkt_yumi_o   = '0;
    dma_data_yumi_o  = '0;
    mem_dma_pkt_o    = pkt_li[sel_id];
    mem_dma_pkt_v_o  = 1'b0;
    mem_dma_data_o   = wdata_li[lock_q];
    mem_dma_data_v_o = 1'b0;
    unique case (state_q)
      e_ready, e_pkt_hold: begin
        mem_dma_pkt_v_o = sel_v & ~reset_i;
        if (mem_dma_pkt_v_o && mem_dma_pkt_ready_and_i) begin
          dma_pkt_yumi_o[sel_id] = 1'b1;
          rr_ptr_d = next_ptr;
          lock_d   = sel_id;
          push     = ~pkt_li[sel_id].write_not_read;
          state_d  = pkt_li[sel_id].write_not_read ? e_wr_data : e_ready;
        end else if (mem_dma_pkt_v_o) begin
          lock_d  = sel_id;
          state_d = e_pkt_hold;
        end
      end
      e_wr_data: begin
        mem_dma_data_v_o = dma_data_v_i[lock_q] & ~reset_i;
        if (mem_dma_data_v_o && mem_dma_data_ready_and_i) begin
          dma_data_yumi_o[lock_q] = 1'b1;
          if (wr_cnt_q == cnt_w_lp'(burst_len_p - 1)) begin
            wr_cnt_d = '0;
            state_d  = e_ready;
          end else begin
            wr_cnt_d = wr_cnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_ready;
      rr_ptr_q <= '0;
      lock_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Fill return path: steer memory fills to the oldest outstanding reader.
  assign fill_v                   = mem_dma_data_v_i & ~trk_empty & ~reset_i;
  assign mem_dma_data_ready_and_o = ~trk_empty & dma_data_ready_and_i[head_id] & ~reset_i;
  assign fill_yumi                = fill_v & mem_dma_data_ready_and_o;
  assign dma_data_o               = {num_dma_p{mem_dma_data_i}};

  always_comb begin
    dma_data_v_o          = '0;
    dma_data_v_o[head_id] = fill_v;
  end

  bp_me_dma_tag_tracker #(
    .num_dma_p    (num_dma_p),
    .burst_len_p  (burst_len_p),
    .outstanding_p(outstanding_p)
  ) u_tracker (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_id_i   (sel_id),
    .fill_yumi_i (fill_yumi),
    .head_o      (head_id),
    .empty_o     (trk_empty),
    .full_c_o    (trk_full),
    .pop_last_c_o(trk_pop)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(dma_pkt_yumi_o)) else $error("multiple packet yumis");
      assert ((dma_pkt_yumi_o & ~dma_pkt_v_i) == '0) else $error("packet yumi without valid");
      assert ((dma_data_yumi_o & ~dma_data_v_i) == '0) else $error("data yumi without valid");
      assert (!(mem_dma_data_v_i && trk_empty)) else $error("fill with no outstanding read");
      assert (!(trk_pop && !fill_yumi)) else $error("tracker pop without fill");
    end
  end

endmodule
